// File: rtl/nrisc_ctrl_pkg.sv
// Shared types and encodings for the nRisc multi-cycle control unit.
package nrisc_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT
    } state_e;

    localparam logic [2:0] OP_ADD   = 3'd0;
    localparam logic [2:0] OP_SHIFT = 3'd1;
    localparam logic [2:0] OP_STORE = 3'd2;
    localparam logic [2:0] OP_LOAD  = 3'd3;
    localparam logic [2:0] OP_ADDI  = 3'd4;
    localparam logic [2:0] OP_BEQ   = 3'd5;
    localparam logic [2:0] OP_SLT   = 3'd6;
    localparam logic [2:0] OP_HALT  = 3'd7;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_SHL = 2'd2;
    localparam logic [1:0] ALU_SLT = 2'd3;

    localparam logic [1:0] RS_MEM = 2'd0;
    localparam logic [1:0] RS_ALU = 2'd1;
    localparam logic [1:0] RS_SLT = 2'd2;

    typedef struct packed {
        logic       pc_write;
        logic       pc_src;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] alu_op;
        logic       alu_src1;
        logic       alu_src2;
        logic [1:0] beq_regs;
        logic [1:0] reg_src;
        logic       reg_write;
        logic       halted;
    } ctrl_t;

endpackage

// File: rtl/nrisc_multicycle_ctrl_decode.sv
// Combinational control-vector decode from (state, op_q, zero); FETCH strobes are
// emitted unconditionally here and qualified by mem_ready in the top.
module nrisc_ctrl_decode
    import nrisc_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 3
) (
    input  state_e              state_i,
    input  logic [OPCODE_W-1:0] op_i,
    input  logic                zero_i,
    output ctrl_t               ctrl_o
);

    logic [2:0] op3;
    assign op3 = op_i[2:0];

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            FETCH: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.ir_write = 1'b1;
                ctrl_o.pc_write = 1'b1;
            end
            EXEC: begin
                case (op3)
                    OP_ADD: ctrl_o.alu_src2 = 1'b1;
                    OP_SHIFT: begin
                        ctrl_o.alu_op   = ALU_SHL;
                        ctrl_o.alu_src1 = 1'b1;
                    end
                    OP_STORE, OP_LOAD: ctrl_o.alu_src2 = 1'b1;
                    OP_ADDI: begin
                        ctrl_o.alu_src1 = 1'b1;
                        ctrl_o.alu_src2 = 1'b1;
                    end
                    OP_BEQ: begin
                        ctrl_o.alu_op   = ALU_SUB;
                        ctrl_o.pc_write = zero_i;
                        ctrl_o.pc_src   = 1'b1;
                    end
                    OP_SLT: begin
                        ctrl_o.alu_op   = ALU_SLT;
                        ctrl_o.beq_regs = 2'd1;
                    end
                    default: ctrl_o.alu_op = ALU_ADD;
                endcase
            end
            MEM: begin
                ctrl_o.mem_write = (op3 == OP_STORE);
                ctrl_o.mem_read  = (op3 != OP_STORE);
            end
            WB: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.reg_src   = (op3 == OP_LOAD) ? RS_MEM :
                                   (op3 == OP_SLT)  ? RS_SLT : RS_ALU;
            end
            HALT:    ctrl_o.halted = 1'b1;
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/nrisc_multicycle_ctrl.sv
// nRisc multi-cycle controller: IDLE/FETCH/DECODE/EXEC/MEM/WB/HALT sequencing with
// memory watchdog and illegal-opcode trap. NRISC_CTRL_PERF_EN adds cycle/instr counters.
module nrisc_multicycle_ctrl
    import nrisc_ctrl_pkg::*;
#(
    parameter int OPCODE_W    = 3,
    parameter int ALUOP_W     = 3,
    parameter int MEM_TIMEOUT = 0
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    input  logic                mem_ready,
    input  logic                resume,
    output logic                pc_write,
    output logic                pc_src,
    output logic                ir_write,
    output logic                mem_read,
    output logic                mem_write,
    output logic [ALUOP_W-1:0]  alu_op,
    output logic                alu_src1,
    output logic                alu_src2,
    output logic [1:0]          beq_regs,
    output logic [1:0]          reg_src,
    output logic                reg_write,
    output logic                halted,
    output logic                fault
`ifdef NRISC_CTRL_PERF_EN
    ,
    output logic [15:0]         cycle_cnt,
    output logic [15:0]         instr_cnt
`endif
);

    localparam int WD_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(MEM_TIMEOUT);

    state_e              state_q, state_d;
    logic [OPCODE_W-1:0] op_q, op_d;
    logic [WD_W-1:0]     wd_q, wd_d;
    logic                fault_q, fault_d;
    logic                waiting, timeout, illegal, fetch_ok;
    ctrl_t               ctrl;

    if (OPCODE_W > 3) begin : g_wide_op
        assign illegal = |opcode[OPCODE_W-1:3];
    end else begin : g_narrow_op
        assign illegal = 1'b0;
    end

    assign waiting = (state_q == FETCH) || (state_q == MEM);
    assign timeout = (MEM_TIMEOUT > 0) && waiting && (wd_q == WD_MAX);

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        fault_d = fault_q;
        case (state_q)
            IDLE:  state_d = FETCH;
            FETCH: begin
                if (timeout) begin
                    state_d = HALT;
                    fault_d = 1'b1;
                end else if (mem_ready) begin
                    state_d = DECODE;
                end
            end
            DECODE: begin
                op_d = opcode;
                if (illegal) begin
                    state_d = HALT;
                    fault_d = 1'b1;
                end else if (opcode[2:0] == OP_HALT) begin
                    state_d = HALT;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                case (op_q[2:0])
                    OP_STORE, OP_LOAD: state_d = MEM;
                    OP_BEQ:            state_d = FETCH;
                    default:           state_d = WB;
                endcase
            end
            MEM: begin
                if (timeout) begin
                    state_d = HALT;
                    fault_d = 1'b1;
                end else if (mem_ready) begin
                    state_d = (op_q[2:0] == OP_STORE) ? FETCH : WB;
                end
            end
            WB:   state_d = FETCH;
            HALT: begin
                if (resume) begin
                    state_d = FETCH;
                    fault_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Watchdog only runs while a request is outstanding; it saturates at WD_MAX.
    always_comb begin
        wd_d = '0;
        if ((MEM_TIMEOUT > 0) && waiting && !mem_ready && (state_d == state_q)) begin
            wd_d = (wd_q == WD_MAX) ? wd_q : wd_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            wd_q    <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            wd_q    <= wd_d;
            fault_q <= fault_d;
        end
    end

    nrisc_ctrl_decode #(.OPCODE_W(OPCODE_W)) u_decode (
        .state_i (state_q),
        .op_i    (op_q),
        .zero_i  (zero),
        .ctrl_o  (ctrl)
    );

    // FETCH strobes commit only on a completed read; a timed-out request is dropped.
    assign fetch_ok  = mem_ready && !timeout;
    assign pc_write  = ctrl.pc_write && (fetch_ok || (state_q != FETCH));
    assign pc_src    = ctrl.pc_src;
    assign ir_write  = ctrl.ir_write && fetch_ok;
    assign mem_read  = ctrl.mem_read && !timeout;
    assign mem_write = ctrl.mem_write && !timeout;
    assign alu_op    = ALUOP_W'(ctrl.alu_op);
    assign alu_src1  = ctrl.alu_src1;
    assign alu_src2  = ctrl.alu_src2;
    assign beq_regs  = ctrl.beq_regs;
    assign reg_src   = ctrl.reg_src;
    assign reg_write = ctrl.reg_write;
    assign halted    = ctrl.halted;
    assign fault     = fault_q;

`ifdef NRISC_CTRL_PERF_EN
    logic [15:0] cycle_q, instr_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cycle_q <= '0;
            instr_q <= '0;
        end else begin
            if ((state_q != IDLE) && (state_q != HALT)) cycle_q <= cycle_q + 16'd1;
            if (state_q == DECODE) instr_q <= instr_q + 16'd1;
        end
    end

    assign cycle_cnt = cycle_q;
    assign instr_cnt = instr_q;
`endif

endmodule

// File: tb/tb_nrisc_multicycle_ctrl.sv
// Directed table-driven bench for nrisc_multicycle_ctrl (default build plus a
// second instance with OPCODE_W=4, MEM_TIMEOUT=4).
module tb_nrisc_multicycle_ctrl;

    typedef struct packed {
        logic       pcw;
        logic       pcs;
        logic       irw;
        logic       mrd;
        logic       mwr;
        logic [2:0] alu;
        logic       s1;
        logic       s2;
        logic [1:0] beq;
        logic [1:0] rs;
        logic       rw;
        logic       hlt;
        logic       flt;
    } ctl_t;

    typedef struct {
        logic [2:0] op;
        logic       z;
        logic       mr;
        logic       res;
        ctl_t       exp;
    } vec_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // Instance 1: default parameters
    logic       reset_n, zero, mem_ready, resume;
    logic [2:0] opcode;
    logic       pc_write, pc_src, ir_write, mem_read, mem_write;
    logic [2:0] alu_op;
    logic       alu_src1, alu_src2, reg_write, halted, fault;
    logic [1:0] beq_regs, reg_src;
    ctl_t       act1;

    // Instance 2: wide opcode, watchdog enabled
    logic       reset2_n, zero2, mem_ready2, resume2;
    logic [3:0] opcode2;
    logic       pc_write2, pc_src2, ir_write2, mem_read2, mem_write2;
    logic [2:0] alu_op2;
    logic       alu_src12, alu_src22, reg_write2, halted2, fault2;
    logic [1:0] beq_regs2, reg_src2;
    ctl_t       act2;

`ifdef NRISC_CTRL_PERF_EN
    logic [15:0] cycle_cnt, instr_cnt, cycle_cnt2, instr_cnt2;
`endif

    nrisc_multicycle_ctrl dut (
        .clock(clock), .reset_n(reset_n), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .resume(resume),
        .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write),
        .mem_read(mem_read), .mem_write(mem_write), .alu_op(alu_op),
        .alu_src1(alu_src1), .alu_src2(alu_src2), .beq_regs(beq_regs),
        .reg_src(reg_src), .reg_write(reg_write), .halted(halted), .fault(fault)
`ifdef NRISC_CTRL_PERF_EN
        , .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
`endif
    );

    nrisc_multicycle_ctrl #(.OPCODE_W(4), .ALUOP_W(3), .MEM_TIMEOUT(4)) dut2 (
        .clock(clock), .reset_n(reset2_n), .opcode(opcode2), .zero(zero2),
        .mem_ready(mem_ready2), .resume(resume2),
        .pc_write(pc_write2), .pc_src(pc_src2), .ir_write(ir_write2),
        .mem_read(mem_read2), .mem_write(mem_write2), .alu_op(alu_op2),
        .alu_src1(alu_src12), .alu_src2(alu_src22), .beq_regs(beq_regs2),
        .reg_src(reg_src2), .reg_write(reg_write2), .halted(halted2), .fault(fault2)
`ifdef NRISC_CTRL_PERF_EN
        , .cycle_cnt(cycle_cnt2), .instr_cnt(instr_cnt2)
`endif
    );

    assign act1 = {pc_write, pc_src, ir_write, mem_read, mem_write, alu_op,
                   alu_src1, alu_src2, beq_regs, reg_src, reg_write, halted, fault};
    assign act2 = {pc_write2, pc_src2, ir_write2, mem_read2, mem_write2, alu_op2,
                   alu_src12, alu_src22, beq_regs2, reg_src2, reg_write2, halted2, fault2};

    int n_vec = 0;
    int n_bad = 0;
    vec_t vq[$];

    function automatic ctl_t mk(input logic pcw, pcs, irw, mrd, mwr,
                                input logic [2:0] alu, input logic s1, s2,
                                input logic [1:0] beq, rs, input logic rw, hlt, flt);
        ctl_t c;
        c = {pcw, pcs, irw, mrd, mwr, alu, s1, s2, beq, rs, rw, hlt, flt};
        return c;
    endfunction

    task automatic add(input logic [2:0] op, input logic z, mr, res, input ctl_t e);
        vec_t v;
        v.op = op; v.z = z; v.mr = mr; v.res = res; v.exp = e;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input ctl_t got, input ctl_t exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        ctl_t c_zero, c_fet, c_fetw, c_ex_add, c_ex_shift, c_ex_addi, c_ex_beq1;
        ctl_t c_ex_beq0, c_ex_slt, c_mem_rd, c_mem_wr, c_wb_alu, c_wb_mem, c_wb_slt, c_hlt;
        int nrd, ncyc;
        logic seen_halt;

        c_zero     = '0;
        c_fet      = mk(1,0,1,1,0, 3'd0,0,0, 2'd0,2'd0, 0,0,0);
        c_fetw     = mk(0,0,0,1,0, 3'd0,0,0, 2'd0,2'd0, 0,0,0);
        c_ex_add   = mk(0,0,0,0,0, 3'd0,0,1, 2'd0,2'd0, 0,0,0);
        c_ex_shift = mk(0,0,0,0,0, 3'd2,1,0, 2'd0,2'd0, 0,0,0);
        c_ex_addi  = mk(0,0,0,0,0, 3'd0,1,1, 2'd0,2'd0, 0,0,0);
        c_ex_beq1  = mk(1,1,0,0,0, 3'd1,0,0, 2'd0,2'd0, 0,0,0);
        c_ex_beq0  = mk(0,1,0,0,0, 3'd1,0,0, 2'd0,2'd0, 0,0,0);
        c_ex_slt   = mk(0,0,0,0,0, 3'd3,0,0, 2'd1,2'd0, 0,0,0);
        c_mem_rd   = mk(0,0,0,1,0, 3'd0,0,0, 2'd0,2'd0, 0,0,0);
        c_mem_wr   = mk(0,0,0,0,1, 3'd0,0,0, 2'd0,2'd0, 0,0,0);
        c_wb_alu   = mk(0,0,0,0,0, 3'd0,0,0, 2'd0,2'd1, 1,0,0);
        c_wb_mem   = mk(0,0,0,0,0, 3'd0,0,0, 2'd0,2'd0, 1,0,0);
        c_wb_slt   = mk(0,0,0,0,0, 3'd0,0,0, 2'd0,2'd2, 1,0,0);
        c_hlt      = mk(0,0,0,0,0, 3'd0,0,0, 2'd0,2'd0, 0,1,0);

        // ADD
        add(0,0,1,0,c_zero);   add(0,0,1,0,c_fet);     add(0,0,1,0,c_zero);
        add(0,0,1,0,c_ex_add); add(0,0,1,0,c_wb_alu);
        // LOAD with three wait cycles in MEM
        add(3,0,1,0,c_fet);    add(3,0,1,0,c_zero);    add(3,0,1,0,c_ex_add);
        add(3,0,0,0,c_mem_rd); add(3,0,0,0,c_mem_rd);  add(3,0,0,0,c_mem_rd);
        add(3,0,1,0,c_mem_rd); add(3,0,1,0,c_wb_mem);
        // BEQ taken, then not taken
        add(5,1,1,0,c_fet);    add(5,1,1,0,c_zero);    add(5,1,1,0,c_ex_beq1);
        add(5,0,1,0,c_fet);    add(5,0,1,0,c_zero);    add(5,0,1,0,c_ex_beq0);
        // STORE with one wait cycle
        add(2,0,1,0,c_fet);    add(2,0,1,0,c_zero);    add(2,0,1,0,c_ex_add);
        add(2,0,0,0,c_mem_wr); add(2,0,1,0,c_mem_wr);
        // SLT with a FETCH stall; mem_ready ignored in EXEC/WB
        add(6,0,0,0,c_fetw);   add(6,0,1,0,c_fet);     add(6,0,1,0,c_zero);
        add(6,0,0,0,c_ex_slt); add(6,0,0,0,c_wb_slt);
        // SHIFT with stray resume
        add(1,0,1,0,c_fet);    add(1,0,1,1,c_zero);    add(1,0,1,1,c_ex_shift);
        add(1,0,1,0,c_wb_alu);
        // ADDI
        add(4,0,1,0,c_fet);    add(4,0,1,0,c_zero);    add(4,0,1,0,c_ex_addi);
        add(4,0,1,0,c_wb_alu);
        // HALT, ten idle cycles, resume
        add(7,0,1,0,c_fet);    add(7,0,1,0,c_zero);
        for (int i = 0; i < 10; i++) add(7, i[0], 1, 0, c_hlt);
        add(7,0,1,1,c_hlt);
        add(0,0,1,0,c_fet);    add(0,0,1,0,c_zero);    add(0,0,1,0,c_ex_add);
        add(0,0,1,0,c_wb_alu);

        reset_n = 1'b0; opcode = '0; zero = 1'b0; mem_ready = 1'b0; resume = 1'b0;
        reset2_n = 1'b0; opcode2 = '0; zero2 = 1'b0; mem_ready2 = 1'b0; resume2 = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        chk("reset_dut1", act1, c_zero);
        chk("reset_dut2", act2, c_zero);

        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < vq.size(); i++) begin
            opcode = vq[i].op; zero = vq[i].z; mem_ready = vq[i].mr; resume = vq[i].res;
            #1;
            chk($sformatf("vec%0d", i), act1, vq[i].exp);
            @(negedge clock);
        end

        // Reset asserted mid-MEM drops the STORE request at once; restart fetches.
        opcode = 3'd2; mem_ready = 1'b1; zero = 1'b0; resume = 1'b0;
        repeat (3) @(negedge clock);
        mem_ready = 1'b0;
        #1;
        chk("store_mem_pending", act1, c_mem_wr);
        #2 reset_n = 1'b0;
        #1;
        chk("reset_mid_mem", act1, c_zero);
        @(negedge clock);
        reset_n = 1'b1;
        mem_ready = 1'b1;
        @(negedge clock);
        #1;
        chk("restart_fetch", act1, c_fet);

        // Watchdog: mem_ready held low in FETCH
        reset2_n = 1'b1;
        nrd = 0; ncyc = 0; seen_halt = 1'b0;
        for (int i = 0; i < 20 && !seen_halt; i++) begin
            @(negedge clock);
            #1;
            if (halted2) seen_halt = 1'b1;
            else begin
                ncyc++;
                if (mem_read2) nrd++;
            end
        end
        chk_int("timeout_reached_halt", int'(seen_halt), 1);
        chk_int("timeout_wait_reads", nrd, 4);
        chk_int("timeout_cycles_in_fetch", ncyc, 5);
        chk("timeout_fault", act2, mk(0,0,0,0,0, 3'd0,0,0, 2'd0,2'd0, 0,1,1));
        @(negedge clock);
        resume2 = 1'b1;
        #1;
        chk("halt_before_resume", act2, mk(0,0,0,0,0, 3'd0,0,0, 2'd0,2'd0, 0,1,1));
        @(negedge clock);
        resume2 = 1'b0;
        #1;
        chk("resume_clears_fault", act2, c_fetw);

        // Illegal opcode 9 with the wide opcode field
        mem_ready2 = 1'b1;
        @(negedge clock);
        opcode2 = 4'd9;
        #1;
        chk("illegal_decode", act2, c_zero);
        @(negedge clock);
        #1;
        chk("illegal_halt_fault", act2, mk(0,0,0,0,0, 3'd0,0,0, 2'd0,2'd0, 0,1,1));
        #2 reset2_n = 1'b0;
        #1;
        chk("illegal_async_reset", act2, c_zero);
        @(negedge clock);
        reset2_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
